uart_tx_fifo: RTL

Buffered 8N1 UART transmitter, the transmit-side counterpart to the design's UART command receiver. It accepts bytes over a valid/ready handshake into a small FIFO and serializes them on `uart_txd` at a fixed bit period. It sits between the command/status logic and the `uo_out[0]` pad, and echoes or reports PWM-sine state back to the host.

---
 rtl/uart_tx_fifo_if.sv | 22 ++
 rtl/uart_tx_fifo.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_if.sv
// Byte handshake between a producer (command/status logic) and the
// buffered UART transmitter. The producer holds tx_data/tx_valid until it
// sees tx_ready high at a rising clock edge.
interface uart_tx_fifo_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  // Producer side: offers bytes, watches ready.
  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  // Transmitter side: accepts bytes when it has room.
  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter.
// Bytes enter a small circular FIFO over a valid/ready handshake and are
// shifted out on uart_txd LSB first, framed by one start bit (0) and one
// stop bit (1). When another byte is waiting at the end of a stop bit, the
// next start bit follows on the very next edge, so bursts have no idle gap.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  uart_tx_fifo_if.slave                tx,
  output logic                         uart_txd,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  COUNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  // FIFO storage and bookkeeping
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  // Serializer state
  state_e           state_q,   state_d;
  logic [BAUD_W-1:0] baud_q,   baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q,   shift_d;
  logic             txd_q,     txd_d;

  logic push;
  logic pop;
  logic fifo_empty;
  logic baud_last;

  // Ready depends only on registered occupancy plus reset, so a push into
  // a full FIFO can never happen and a held tx_valid is simply ignored.
  assign tx.tx_ready = rst_n & (count_q != COUNT_FULL);
  assign push        = tx.tx_valid & tx.tx_ready;
  assign fifo_empty  = (count_q == '0);
  assign baud_last   = (baud_q == BAUD_LAST);

  assign uart_txd   = txd_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != IDLE) | (count_q != '0);

  // Serializer next state: the line value for the coming cycle is decided
  // here together with the state so uart_txd comes straight from a flop.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
    pop       = 1'b0;

    case (state_q)
      IDLE: begin
        txd_d     = 1'b1;
        baud_d    = '0;
        bit_idx_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_mem[rd_ptr_q];
          state_d = START;
          txd_d   = 1'b0;
        end
      end

      START: begin
        if (baud_last) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = DATA;
          txd_d     = shift_q[0];
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            txd_d     = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      STOP: begin
        if (baud_last) begin
          baud_d    = '0;
          bit_idx_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_mem[rd_ptr_q];
            state_d = START;
            txd_d   = 1'b0;
          end else begin
            state_d = IDLE;
            txd_d   = 1'b1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      default: begin
        state_d   = IDLE;
        baud_d    = '0;
        bit_idx_d = '0;
        txd_d     = 1'b1;
      end
    endcase
  end

  // FIFO pointer and occupancy update; a push and a pop together cancel.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset abandons any frame in flight and flushes the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Byte storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= tx.tx_data;
    end
  end

  // Occupancy must stay within the FIFO and a pop must find a byte.
  assert property (@(posedge clk) disable iff (!rst_n) count_q <= COUNT_FULL);
  assert property (@(posedge clk) disable iff (!rst_n) !(pop && fifo_empty));

endmodule
